// File: rtl/fetch.sv
// Instruction fetch: PC register, in-order imem request issue, and a small {pc, insn} FIFO feeding decode.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_o / stall_cnt_o performance counters.
module fetch #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              imem_req_valid_o,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_req_ready_i,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       stall_cnt_o
`endif
);

  // Handshake: a request transfers on a cycle where imem_req_valid_o && imem_req_ready_i at posedge clk;
  // responses have no backpressure; decode takes the head when valid_o && !stall_i (and no redirect).

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [DWIDTH-1:0] NOP = DWIDTH'(32'h0000_0013);

  logic [AWIDTH-1:0] pc_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     outstanding_q;
  logic [CW-1:0]     drop_q;

  logic [AWIDTH-1:0] pcq_mem [DEPTH];
  logic [PW-1:0]     pcq_wr;
  logic [PW-1:0]     pcq_rd;

  logic [AWIDTH-1:0] fifo_pc   [DEPTH];
  logic [DWIDTH-1:0] fifo_insn [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic accept;
  logic rsp;
  logic discard;
  logic push;
  logic pop;
  logic [CW:0] occupancy;
  logic [1:0]  unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc_i[1:0];

  always_comb begin
    occupancy        = {1'b0, count_q} + {1'b0, outstanding_q};
    imem_req_valid_o = !rst && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    imem_req_addr_o  = pc_q;
    accept           = imem_req_valid_o && imem_req_ready_i;
    rsp              = imem_rsp_valid_i;
    discard          = rsp && (drop_q != '0);
    push             = rsp && (drop_q == '0) && !redirect_i;
    valid_o          = !rst && (count_q != '0);
    pop              = valid_o && !stall_i && !redirect_i;
    pc_o             = BASEADDR;
    insn_o           = NOP;
    if (valid_o) begin
      pc_o   = fifo_pc[rd_ptr];
      insn_o = fifo_insn[rd_ptr];
    end else if (!rst) begin
      pc_o   = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= BASEADDR;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      pcq_wr        <= '0;
      pcq_rd        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(accept) - CW'(rsp);
      if (accept) pcq_wr <= pcq_wr + 1'b1;
      if (rsp)    pcq_rd <= pcq_rd + 1'b1;
      if (redirect_i) begin
        // Everything still in flight after this cycle belongs to the old stream.
        pc_q    <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
        count_q <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        drop_q  <= outstanding_q - CW'(rsp);
      end else begin
        if (accept) pc_q <= pc_q + AWIDTH'(4);
        drop_q  <= drop_q - CW'(discard);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcq_mem[pcq_wr] <= pc_q;
    if (push) begin
      fifo_pc[wr_ptr]   <= pcq_mem[pcq_rd];
      fifo_insn[wr_ptr] <= imem_rsp_data_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (pop)                fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (valid_o && stall_i) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == CW'(DEPTH))));

endmodule
